fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end for the 16-bit CPU. Owns the program counter, issues word reads to instruction memory over a request/grant/response handshake, and buffers returned words in a small prefetch queue. It feeds decode (control unit and register-file read ports) through a valid/ready interface. It also supports PC redirects and stops fetching on the halt word.

## Interface
- `ADDR_W`, 16: PC and memory address width.
- `DEPTH`, 2: prefetch queue entries. Must be a power of 2, ≥2.
- `RESET_PC`, 16'h0000: PC loaded on reset.

- `clock`  input  1  sole clock; all state updates on posedge.
- `reset`  input  1  asynchronous, active-low reset.
- `imem_req`  output  1  read request.
- `imem_addr`  output  ADDR_W  byte address of the request.
- `imem_gnt`  input  1  request accepted when `imem_req && imem_gnt`.
- `imem_rvalid`  input  1  read data valid. Responses arrive in order, ≥1 cycle after grant.
- `imem_rdata`  input  16  instruction word.
- `redirect_valid`  input  1  load new fetch PC.
- `redirect_pc`  input  ADDR_W  redirect target.
- `inst_valid`  output  1  queue head valid.
- `inst`  output  16  queue head instruction.
- `inst_pc`  output  ADDR_W  address of `inst`.
- `inst_ready`  input  1  decode accepts head when `inst_valid && inst_ready`.
- `halted`  output  1  halt word has been consumed and fetch is stopped.

## Operation
- FSM states:
  - RUN: issue requests. Transition RUN→HALT when the halt word 16'hFFFF is dequeued.
  - HALT: no requests; `halted`=1. Transition HALT→RUN only on `redirect_valid`.
- Credit rule: assert `imem_req` only when in RUN, no halt word is queued, and `count + outstanding < DEPTH`.
  - Because of this rule the queue never overflows.
- Each grant:
  - `fetch_pc += 2`, mod 2^ADDR_W; wraps from 16'hFFFE to 16'h0000.
  - `outstanding++`.
  - The granted address is tagged into a PC side-FIFO.
- Each `imem_rvalid`:
  - `outstanding--`.
  - If `drop_cnt > 0`: discard the word and `drop_cnt--`.
  - Otherwise enqueue `{rdata, pc}`.
- Halt word:
  - It is enqueued and delivered to decode like any other word.
  - Once it is in the queue, no further requests are issued.
  - Any later returning responses are discarded.
- Redirect:
  - The queue is flushed.
  - `drop_cnt` is set to `outstanding` after this cycle's grant and response accounting, so a response returning in the same cycle is discarded.
  - `fetch_pc` is set to `redirect_pc`.
  - The FSM goes to RUN.
  - An `imem_req` in the redirect cycle still uses the old address; if granted, that response is dropped.
- Simultaneous events:
  - Dequeue and enqueue in the same cycle: both occur; count is unchanged.
  - Dequeue and redirect in the same cycle: decode takes the head, then the flush occurs.
  - Redirect in the same cycle as the halt-word dequeue: redirect wins and the FSM stays in RUN.
- `inst` and `inst_pc` hold their values while `inst_valid`=0.

## Timing
- Reset values:
  - `imem_req`=0
  - `imem_addr`=`RESET_PC`
  - `inst_valid`=0
  - `inst`=0
  - `inst_pc`=0
  - `halted`=0
  - queue empty; `outstanding` and `drop_cnt` = 0
- First `imem_req` is asserted the first posedge after reset deasserts.
- `imem_addr` equals `fetch_pc` combinationally.
- Latency from `imem_rvalid` to `inst_valid` is 1 cycle (registered queue).
- With 1-cycle memory latency, `gnt`=1, `inst_ready`=1 and `DEPTH`≥2, sustained throughput is 1 instruction per cycle.
- `halted` rises the cycle after the halt word's dequeue edge.
- Reset asserted mid-operation clears all state immediately (asynchronous). Responses still in flight afterwards are the memory's responsibility; the memory must also reset.

## Configuration
- `FETCH_PERF_EN`, when defined:
  - Adds outputs `perf_fetched` (16 bits, count of dequeued instructions).
  - Adds `perf_stall` (16 bits, cycles with `inst_ready && !inst_valid` in RUN).
  - Both counters saturate at 16'hFFFF and reset to 0.
- When not defined: no counters and no extra ports.

## Structure
- `cpu_pkg` holds:
  - `HALT_WORD`=16'hFFFF
  - `PC_STEP`=2
  - the instruction-word typedef, shared with decode/control
- Submodule `fetch_fifo`:
  - parameterized by width and `DEPTH`
  - ptr wrap plus count; flush port
  - instantiated for the `{inst, pc}` entries

## Test plan
- Reset release, `gnt`=1, 1-cycle memory with words 16'h2009, 16'h200A, … → addresses 0, 2, 4, …; `inst_pc`=0, 2 on back-to-back cycles; 1 instr/cycle.
- `inst_ready`=0 for 5 cycles → at most `DEPTH` outstanding plus queued; `imem_req` drops; no word lost or duplicated after release.
- Redirect to 16'h0040 with 2 responses in flight → both dropped; next `inst_pc`=16'h0040.
- 16'hFFFF at address 8 → delivered with `inst_pc`=8; no request to address 12; `halted`=1 the cycle after acceptance. Then redirect to 0 → `halted`=0 and fetch resumes at 0.
- Redirect to 16'hFFFE → next fetch address 16'h0000.
- Assert `reset` while the queue is full → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the fetch front end and decode/control.
package cpu_pkg;

  typedef logic [15:0] inst_word_t;

  localparam inst_word_t  HALT_WORD = 16'hFFFF;
  localparam int unsigned PC_STEP   = 2;

  typedef enum logic {
    FETCH_RUN,
    FETCH_HALT
  } fetch_state_e;

  function automatic logic is_halt(input inst_word_t word);
    return word == HALT_WORD;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small power-of-two FIFO with wrapping pointers, occupancy count and flush.
// While empty the head output keeps showing the last entry that left the FIFO.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       head_valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [WIDTH-1:0] hold_data;
  logic             do_push;
  logic             do_pop;

  assign head_valid = count != '0;
  assign do_pop     = pop && head_valid;
  assign do_push    = push && !flush && (count != CNT_W'(DEPTH) || do_pop);
  assign head_data  = head_valid ? mem[rd_ptr] : hold_data;

  // The outgoing head is captured on pop or flush so the output is stable once empty.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      hold_data <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_pop || (flush && head_valid)) hold_data <= mem[rd_ptr];
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= push_data;
          wr_ptr      <= wr_ptr + PTR_W'(1);
        end
        if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (do_push && !do_pop)      count <= count + CNT_W'(1);
        else if (do_pop && !do_push) count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, requests instruction words and queues them for decode.
// Defining FETCH_PERF_EN adds saturating perf_fetched / perf_stall counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [15:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [15:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_stall
`endif
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = 16 + ADDR_W;

  fetch_state_e      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_en;
  logic              halt_seen;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  outstanding_next;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  q_count;
  logic [CNT_W:0]    credit_used;
  logic              grant;
  logic              pop;
  logic              enq;
  logic              halt_pop;
  logic              tag_valid;
  logic [ADDR_W-1:0] rsp_pc;
  logic [ENTRY_W-1:0] head_entry;

  assign grant            = imem_req && imem_gnt;
  assign pop              = inst_valid && inst_ready;
  assign halt_pop         = pop && is_halt(inst);
  assign outstanding_next = outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid);
  assign enq              = imem_rvalid && tag_valid && (drop_cnt == '0) && !halt_seen
                            && !redirect_valid;

  // A slot freed by this cycle's dequeue may back a new request, since its response
  // cannot arrive before the next cycle; this keeps one instruction per cycle at DEPTH=2.
  assign credit_used = (CNT_W+1)'(q_count - CNT_W'(pop)) + (CNT_W+1)'(outstanding);
  assign imem_req    = fetch_en && (state == FETCH_RUN) && !halt_seen
                       && (credit_used < (CNT_W+1)'(DEPTH));
  assign imem_addr   = fetch_pc;

  assign inst    = head_entry[ENTRY_W-1 -: 16];
  assign inst_pc = head_entry[ADDR_W-1:0];

  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (1'b0),
    .push       (grant),
    .push_data  (fetch_pc),
    .pop        (imem_rvalid),
    .head_data  (rsp_pc),
    .head_valid (tag_valid),
    .count      (outstanding)
  );

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (enq),
    .push_data  ({imem_rdata, rsp_pc}),
    .pop        (inst_ready),
    .head_data  (head_entry),
    .head_valid (inst_valid),
    .count      (q_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= FETCH_RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        FETCH_RUN: begin
          if (halt_pop && !redirect_valid) begin
            state  <= FETCH_HALT;
            halted <= 1'b1;
          end
        end
        FETCH_HALT: begin
          if (redirect_valid) begin
            state  <= FETCH_RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= FETCH_RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // Responses still in flight at a redirect are counted into drop_cnt and discarded on return.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc  <= RESET_PC;
      fetch_en  <= 1'b0;
      drop_cnt  <= '0;
      halt_seen <= 1'b0;
    end else begin
      fetch_en <= 1'b1;
      if (redirect_valid)  fetch_pc <= redirect_pc;
      else if (grant)      fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      if (redirect_valid)                        drop_cnt <= outstanding_next;
      else if (imem_rvalid && drop_cnt != '0)    drop_cnt <= drop_cnt - CNT_W'(1);
      if (redirect_valid)                        halt_seen <= 1'b0;
      else if (enq && is_halt(imem_rdata))       halt_seen <= 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop && perf_fetched != 16'hFFFF) perf_fetched <= perf_fetched + 16'd1;
      if (state == FETCH_RUN && inst_ready && !inst_valid && perf_stall != 16'hFFFF)
        perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against an in-order
// memory model and a program-order reference of the expected instruction stream.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_stall;
`endif

  always #5 clock = ~clock;

  fetch_unit #(
    .ADDR_W   (16),
    .DEPTH    (DEPTH),
    .RESET_PC (16'h0000)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .halted         (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [15:0] exp_pc, exp_fetch_pc;
  bit          exp_halted;
  logic [15:0] prev_inst, prev_pc;
  logic [15:0] halt_addr = 16'h0;
  bit          halt_en = 1'b0;
  logic [15:0] forbid_addr = 16'h0;
  bit          forbid_en = 1'b0;
  int          mem_lat_min = 1;
  int          mem_lat_max = 1;
  logic [15:0] mq_addr[$];
  int          mq_due[$];
  bit          s_req, s_valid, s_halted, s_pop;
  logic [15:0] s_inst, s_pc;

  // Program image: a running pattern starting at 16'h2009, with an optional halt word.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (halt_en && a == halt_addr) return 16'hFFFF;
    return 16'h2009 + {1'b0, a[15:1]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_output();
    s_req    = imem_req;
    s_valid  = inst_valid;
    s_halted = halted;
    s_inst   = inst;
    s_pc     = inst_pc;
    s_pop    = inst_valid && inst_ready;
    check("imem_addr", imem_addr, exp_fetch_pc);
    check("halted", 16'(halted), 16'(exp_halted));
    if (exp_halted) begin
      check("req_while_halted", 16'(imem_req), 16'd0);
      check("valid_while_halted", 16'(inst_valid), 16'd0);
    end
    if (!inst_valid) begin
      check("hold_inst", inst, prev_inst);
      check("hold_pc", inst_pc, prev_pc);
    end
    if (s_pop) begin
      check("inst_pc", inst_pc, exp_pc);
      check("inst", inst, mem_word(exp_pc));
    end
    if (forbid_en && imem_req)
      check("forbidden_addr", 16'(imem_addr != forbid_addr), 16'd1);
  endtask

  // One clock cycle: drive inputs and memory response, check, update the model, advance.
  task automatic apply_stimulus(input bit rdy, input bit gnt, input bit redir,
                                input logic [15:0] tgt);
    bit fire;
    inst_ready     = rdy;
    imem_gnt       = gnt;
    redirect_valid = redir;
    redirect_pc    = tgt;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'($urandom);
    end
    #1;
    check_output();
    fire = imem_req && imem_gnt;
    if (fire) begin
      mq_addr.push_back(imem_addr);
      mq_due.push_back(cyc + int'($urandom_range(mem_lat_min, mem_lat_max)));
      exp_fetch_pc = exp_fetch_pc + 16'd2;
    end
    check("outstanding_bound", 16'(mq_addr.size() <= DEPTH), 16'd1);
    if (s_pop) begin
      if (mem_word(exp_pc) == 16'hFFFF && !redir) exp_halted = 1'b1;
      exp_pc = exp_pc + 16'd2;
    end
    if (redir) begin
      exp_pc       = tgt;
      exp_fetch_pc = tgt;
      exp_halted   = 1'b0;
    end
    prev_inst = inst;
    prev_pc   = inst_pc;
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic do_reset();
    inst_ready     = 1'b0;
    imem_gnt       = 1'b0;
    redirect_valid = 1'b0;
    #2 reset = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    check("rst_imem_req", 16'(imem_req), 16'd0);
    check("rst_imem_addr", imem_addr, 16'h0000);
    check("rst_inst_valid", 16'(inst_valid), 16'd0);
    check("rst_inst", inst, 16'h0000);
    check("rst_inst_pc", inst_pc, 16'h0000);
    check("rst_halted", 16'(halted), 16'd0);
    mq_addr.delete();
    mq_due.delete();
    exp_pc       = 16'h0000;
    exp_fetch_pc = 16'h0000;
    exp_halted   = 1'b0;
    prev_inst    = 16'h0000;
    prev_pc      = 16'h0000;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    bit found;

    // Reset release and back-to-back streaming
    do_reset();
    #1 check("req_pre_edge", 16'(imem_req), 16'd0);
    for (int k = 1; k <= 14; k++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0);
      if (k == 1) check("req_before_first_edge", 16'(s_req), 16'd0);
      if (k == 2) check("first_req", 16'(s_req), 16'd1);
      if (k >= 4) check("stream_valid", 16'(s_valid), 16'd1);
    end

    // Decode stall: requests stop once the queue and in-flight slots are used
    for (int k = 1; k <= 5; k++) apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0);
    check("req_stall", 16'(s_req), 16'd0);
    for (int k = 0; k < 8; k++) apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0);

    // Redirect with two responses in flight
    mem_lat_min = 3;
    mem_lat_max = 3;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (mq_addr.size() == 2) found = 1'b1;
      else apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0);
    end
    check("two_in_flight", 16'(found), 16'd1);
    apply_stimulus(1'b1, 1'b1, 1'b1, 16'h0040);
    mem_lat_min = 1;
    mem_lat_max = 1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0);
      found = s_pop;
    end
    check("redir_pc", found ? s_pc : 16'hDEAD, 16'h0040);

    // Halt word at address 8
    halt_en     = 1'b1;
    halt_addr   = 16'h0008;
    forbid_en   = 1'b1;
    forbid_addr = 16'h000C;
    apply_stimulus(1'b1, 1'b1, 1'b1, 16'h0000);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0);
      found = s_pop && (s_inst == 16'hFFFF);
    end
    check("halt_pc", found ? s_pc : 16'hDEAD, 16'h0008);
    apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0);
    check("halt_rise", 16'(s_halted), 16'd1);
    for (int k = 0; k < 4; k++) apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 16'h0000);
    apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0);
    check("halt_clear", 16'(s_halted), 16'd0);
    found = s_pop;
    for (int k = 0; k < 20 && !found; k++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0);
      found = s_pop;
    end
    check("resume_pc", found ? s_pc : 16'hDEAD, 16'h0000);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0);
      found = s_halted;
    end
    check("halt_again", 16'(found), 16'd1);
    halt_en   = 1'b0;
    forbid_en = 1'b0;

    // Redirect to the top of the address space wraps to zero
    apply_stimulus(1'b1, 1'b1, 1'b1, 16'hFFFE);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0);
      found = s_pop;
    end
    check("wrap_pc0", found ? s_pc : 16'hDEAD, 16'hFFFE);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0);
      found = s_pop;
    end
    check("wrap_pc1", found ? s_pc : 16'hDEAD, 16'h0000);

    // Randomized traffic: handshakes, memory latency and redirects
    mem_lat_min = 1;
    mem_lat_max = 3;
    for (int k = 0; k < 600; k++) begin
      bit redir;
      redir = ($urandom_range(0, 19) == 0);
      apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, redir,
                     16'($urandom) & 16'hFFFE);
    end

    // Asynchronous reset with a full queue
    mem_lat_min = 1;
    mem_lat_max = 1;
    for (int k = 0; k < 6; k++) apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0);
    do_reset();
    for (int k = 0; k < 8; k++) apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0);
    check("post_reset_stream", 16'(s_valid), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
